// File: rtl/pkt_framer_if.sv
// pkt_framer_if: Avalon-ST style packet stream bundle (no backpressure).
//   data  : payload word
//   sop   : start-of-packet marker
//   eop   : end-of-packet marker
//   empty : unused symbols on the eop beat
//   valid : beat qualifier
// master drives the stream, slave receives it.
interface pkt_framer_if #(
  parameter int DATA_W  = 8,
  parameter int EMPTY_W = 2
);
  logic [DATA_W-1:0]  data;
  logic               sop;
  logic               eop;
  logic [EMPTY_W-1:0] empty;
  logic               valid;

  modport master (output data, sop, eop, empty, valid);
  modport slave  (input  data, sop, eop, empty, valid);
endinterface

// File: rtl/pkt_framer.sv
// pkt_framer: enforces strict sop..eop framing on a packet stream.
// Stray beats outside a packet are dropped; a packet interrupted by a new
// sop, or idle for TIMEOUT cycles, is closed by forcing eop onto its last
// held beat. Saturating counters report emitted/truncated/dropped traffic.
// Ports:
//   sys_clk     : clock, rising edge
//   reset_n     : asynchronous active-low reset
//   in          : upstream stream (slave)
//   clr_cnt     : synchronous clear of the statistics counters
//   out         : framed stream, registered (master)
//   pkt_count   : beats emitted with eop=1 (normal and forced)
//   trunc_count : packets closed by a forced eop
//   drop_count  : input beats discarded
// DATA_W/EMPTY_W must match the widths of the connected interfaces.
module pkt_framer #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8,
  parameter int CNT_W   = 16,
  parameter int DATA_W  = 8,
  parameter int EMPTY_W = 2
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  pkt_framer_if.slave      in,
  input  logic             clr_cnt,
  pkt_framer_if.master     out,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] trunc_count,
  output logic [CNT_W-1:0] drop_count
);

  typedef enum logic {IDLE, OPEN} state_e;

  localparam logic [TO_W-1:0] TIMEOUT_V = TO_W'(TIMEOUT);

  state_e state_q, state_d;

  logic               hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0]  hold_data_q,  hold_data_d;
  logic               hold_sop_q,   hold_sop_d;
  logic               hold_eop_q,   hold_eop_d;
  logic [EMPTY_W-1:0] hold_empty_q, hold_empty_d;

  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q,  out_data_d;
  logic               out_sop_q,   out_sop_d;
  logic               out_eop_q,   out_eop_d;
  logic [EMPTY_W-1:0] out_empty_q, out_empty_d;

  logic [TO_W-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0]   pkt_cnt_q,   pkt_cnt_d;
  logic [CNT_W-1:0]   trunc_cnt_q, trunc_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q,  drop_cnt_d;

  logic [TO_W-1:0]    timer_inc;
  logic               timeout_fire;
  logic               emit, force_eop, load, drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic inc);
    return (inc && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
  endfunction

  // Timeout fires on the idle cycle that brings the count up to TIMEOUT.
  assign timer_inc    = timer_q + 1'b1;
  assign timeout_fire = (state_q == OPEN) && !in.valid && (timer_inc == TIMEOUT_V);

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_sop_q   <= 1'b0;
      hold_eop_q   <= 1'b0;
      hold_empty_q <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_empty_q  <= '0;
      timer_q      <= '0;
      pkt_cnt_q    <= '0;
      trunc_cnt_q  <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_sop_q   <= hold_sop_d;
      hold_eop_q   <= hold_eop_d;
      hold_empty_q <= hold_empty_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      out_empty_q  <= out_empty_d;
      timer_q      <= timer_d;
      pkt_cnt_q    <= pkt_cnt_d;
      trunc_cnt_q  <= trunc_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // A packet stays OPEN until a beat carrying eop is loaded or it times out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in.valid && in.sop && !in.eop) state_d = OPEN;
      OPEN: begin
        if (in.valid)         state_d = in.eop ? IDLE : OPEN;
        else if (timeout_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: decide emission from hold, then any same-cycle load.
  always_comb begin
    emit      = 1'b0;
    force_eop = 1'b0;
    load      = 1'b0;
    drop      = 1'b0;
    timer_d   = timer_q;

    // A held eop beat always leaves on the following cycle.
    if (hold_valid_q && hold_eop_q) emit = 1'b1;

    case (state_q)
      IDLE: begin
        if (in.valid) begin
          if (in.sop) begin
            load    = 1'b1;
            timer_d = '0;
          end else begin
            drop = 1'b1;
          end
        end
      end
      OPEN: begin
        if (in.valid) begin
          emit      = 1'b1;
          force_eop = in.sop;
          load      = 1'b1;
          timer_d   = '0;
        end else if (timeout_fire) begin
          emit      = 1'b1;
          force_eop = 1'b1;
          timer_d   = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      default: ;
    endcase

    hold_valid_d = hold_valid_q & ~emit;
    hold_data_d  = hold_data_q;
    hold_sop_d   = hold_sop_q;
    hold_eop_d   = hold_eop_q;
    hold_empty_d = hold_empty_q;
    if (load) begin
      hold_valid_d = 1'b1;
      hold_data_d  = in.data;
      hold_sop_d   = in.sop;
      hold_eop_d   = in.eop;
      hold_empty_d = in.empty;
    end

    // Empty is only meaningful on a genuine eop; forced eops carry zero.
    out_valid_d = emit;
    out_data_d  = emit ? hold_data_q : '0;
    out_sop_d   = emit & hold_sop_q;
    out_eop_d   = emit & (hold_eop_q | force_eop);
    out_empty_d = (emit && hold_eop_q) ? hold_empty_q : '0;

    if (clr_cnt) begin
      pkt_cnt_d   = '0;
      trunc_cnt_d = '0;
      drop_cnt_d  = '0;
    end else begin
      pkt_cnt_d   = sat_inc(pkt_cnt_q, out_eop_d);
      trunc_cnt_d = sat_inc(trunc_cnt_q, emit & force_eop & ~hold_eop_q);
      drop_cnt_d  = sat_inc(drop_cnt_q, drop);
    end
  end

  assign out.valid   = out_valid_q;
  assign out.data    = out_data_q;
  assign out.sop     = out_sop_q;
  assign out.eop     = out_eop_q;
  assign out.empty   = out_empty_q;
  assign pkt_count   = pkt_cnt_q;
  assign trunc_count = trunc_cnt_q;
  assign drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_pkt_framer.sv
// tb_pkt_framer: directed, table-driven bench for pkt_framer.
// Main DUT uses TIMEOUT=4; a second copy with CNT_W=2 shares the input
// stream and is used for counter saturation.
module tb_pkt_framer;

  logic sys_clk = 1'b0;
  logic reset_n = 1'b0;
  logic clr_cnt = 1'b0;

  logic [15:0] pkt_count, trunc_count, drop_count;
  logic [1:0]  pkt_count2, trunc_count2, drop_count2;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  pkt_framer_if #(.DATA_W(8), .EMPTY_W(2)) in_if ();
  pkt_framer_if #(.DATA_W(8), .EMPTY_W(2)) out_if ();
  pkt_framer_if #(.DATA_W(8), .EMPTY_W(2)) out2_if ();

  pkt_framer #(.TIMEOUT(4), .TO_W(8), .CNT_W(16), .DATA_W(8), .EMPTY_W(2)) dut (
    .sys_clk     (sys_clk),
    .reset_n     (reset_n),
    .in          (in_if),
    .clr_cnt     (clr_cnt),
    .out         (out_if),
    .pkt_count   (pkt_count),
    .trunc_count (trunc_count),
    .drop_count  (drop_count)
  );

  pkt_framer #(.TIMEOUT(4), .TO_W(8), .CNT_W(2), .DATA_W(8), .EMPTY_W(2)) dut_sat (
    .sys_clk     (sys_clk),
    .reset_n     (reset_n),
    .in          (in_if),
    .clr_cnt     (clr_cnt),
    .out         (out2_if),
    .pkt_count   (pkt_count2),
    .trunc_count (trunc_count2),
    .drop_count  (drop_count2)
  );

  typedef struct {
    string      name;
    logic       clr, v, s, e;
    logic [7:0] d;
    logic [1:0] emp;
    logic       ov, os, oe;
    logic [7:0] od;
    logic [1:0] oemp;
    int         pc, tc, dc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string n, logic clr, logic v, logic s, logic e,
                              logic [7:0] d, logic [1:0] emp,
                              logic ov, logic os, logic oe, logic [7:0] od,
                              logic [1:0] oemp, int pc, int tc, int dc);
    vec_t r;
    r.name = n; r.clr = clr; r.v = v; r.s = s; r.e = e; r.d = d; r.emp = emp;
    r.ov = ov; r.os = os; r.oe = oe; r.od = od; r.oemp = oemp;
    r.pc = pc; r.tc = tc; r.dc = dc;
    return r;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of input, clock it, and settle 1ns past the edge.
  task automatic applyStimulus(input vec_t t);
    clr_cnt      = t.clr;
    in_if.valid  = t.v;
    in_if.sop    = t.s;
    in_if.eop    = t.e;
    in_if.data   = t.d;
    in_if.empty  = t.emp;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t t);
    checkVal({t.name, "_out"},
             {19'd0, out_if.valid, out_if.sop, out_if.eop, out_if.data, out_if.empty},
             {19'd0, t.ov, t.os, t.oe, t.od, t.oemp});
    checkVal({t.name, "_pkt"},   32'(pkt_count),   32'(t.pc));
    checkVal({t.name, "_trunc"}, 32'(trunc_count), 32'(t.tc));
    checkVal({t.name, "_drop"},  32'(drop_count),  32'(t.dc));
  endtask

  initial begin
    vec_t t;

    in_if.valid = 1'b0; in_if.sop = 1'b0; in_if.eop = 1'b0;
    in_if.data  = '0;   in_if.empty = '0;

    // Clean 3-beat packet
    tbl.push_back(mk("t1_clr", 1,0,0,0,8'h00,2'd0, 0,0,0,8'h00,2'd0, 0,0,0));
    tbl.push_back(mk("t1_a",   0,1,1,0,8'h0A,2'd0, 0,0,0,8'h00,2'd0, 0,0,0));
    tbl.push_back(mk("t1_b",   0,1,0,0,8'h0B,2'd0, 1,1,0,8'h0A,2'd0, 0,0,0));
    tbl.push_back(mk("t1_c",   0,1,0,1,8'h0C,2'd2, 1,0,0,8'h0B,2'd0, 0,0,0));
    tbl.push_back(mk("t1_i0",  0,0,0,0,8'h00,2'd0, 1,0,1,8'h0C,2'd2, 1,0,0));
    tbl.push_back(mk("t1_i1",  0,0,0,0,8'h00,2'd0, 0,0,0,8'h00,2'd0, 1,0,0));
    // Stray beats then a single-beat packet; idle beat with junk fields
    tbl.push_back(mk("t2_clr", 1,0,0,0,8'h00,2'd0, 0,0,0,8'h00,2'd0, 0,0,0));
    tbl.push_back(mk("t2_s1",  0,1,0,0,8'h01,2'd0, 0,0,0,8'h00,2'd0, 0,0,1));
    tbl.push_back(mk("t2_s2",  0,1,0,0,8'h02,2'd0, 0,0,0,8'h00,2'd0, 0,0,2));
    tbl.push_back(mk("t2_one", 0,1,1,1,8'h05,2'd0, 0,0,0,8'h00,2'd0, 0,0,2));
    tbl.push_back(mk("t2_i0",  0,0,1,1,8'hFF,2'd3, 1,1,1,8'h05,2'd0, 1,0,2));
    tbl.push_back(mk("t2_i1",  0,0,0,0,8'h00,2'd0, 0,0,0,8'h00,2'd0, 1,0,2));
    // Packet interrupted by a new sop
    tbl.push_back(mk("t3_clr", 1,0,0,0,8'h00,2'd0, 0,0,0,8'h00,2'd0, 0,0,0));
    tbl.push_back(mk("t3_a",   0,1,1,0,8'h0A,2'd0, 0,0,0,8'h00,2'd0, 0,0,0));
    tbl.push_back(mk("t3_b",   0,1,0,0,8'h0B,2'd3, 1,1,0,8'h0A,2'd0, 0,0,0));
    tbl.push_back(mk("t3_d",   0,1,1,0,8'h0D,2'd0, 1,0,1,8'h0B,2'd0, 1,1,0));
    tbl.push_back(mk("t3_e",   0,1,0,1,8'h0E,2'd1, 1,1,0,8'h0D,2'd0, 1,1,0));
    tbl.push_back(mk("t3_i0",  0,0,0,0,8'h00,2'd0, 1,0,1,8'h0E,2'd1, 2,1,0));
    tbl.push_back(mk("t3_i1",  0,0,0,0,8'h00,2'd0, 0,0,0,8'h00,2'd0, 2,1,0));
    // Timeout after 4 idle cycles, then a stray beat
    tbl.push_back(mk("t4_clr", 1,0,0,0,8'h00,2'd0, 0,0,0,8'h00,2'd0, 0,0,0));
    tbl.push_back(mk("t4_a",   0,1,1,0,8'h0A,2'd0, 0,0,0,8'h00,2'd0, 0,0,0));
    tbl.push_back(mk("t4_b",   0,1,0,0,8'h0B,2'd0, 1,1,0,8'h0A,2'd0, 0,0,0));
    tbl.push_back(mk("t4_w1",  0,0,0,0,8'h00,2'd0, 0,0,0,8'h00,2'd0, 0,0,0));
    tbl.push_back(mk("t4_w2",  0,0,0,0,8'h00,2'd0, 0,0,0,8'h00,2'd0, 0,0,0));
    tbl.push_back(mk("t4_w3",  0,0,0,0,8'h00,2'd0, 0,0,0,8'h00,2'd0, 0,0,0));
    tbl.push_back(mk("t4_w4",  0,0,0,0,8'h00,2'd0, 1,0,1,8'h0B,2'd0, 1,1,0));
    tbl.push_back(mk("t4_str", 0,1,0,0,8'h0F,2'd0, 0,0,0,8'h00,2'd0, 1,1,1));
    tbl.push_back(mk("t4_i0",  0,0,0,0,8'h00,2'd0, 0,0,0,8'h00,2'd0, 1,1,1));

    // Reset state
    repeat (2) @(posedge sys_clk);
    #1;
    t = mk("rst", 0,0,0,0,8'h00,2'd0, 0,0,0,8'h00,2'd0, 0,0,0);
    checkOutput(t);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i]);
    end

    // Reset mid-packet: open A,B then pull reset asynchronously
    t = mk("t5_a", 0,1,1,0,8'h0A,2'd0, 0,0,0,8'h00,2'd0, 1,1,1);
    applyStimulus(t); checkOutput(t);
    t = mk("t5_b", 0,1,0,0,8'h0B,2'd0, 1,1,0,8'h0A,2'd0, 1,1,1);
    applyStimulus(t); checkOutput(t);
    in_if.valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    t = mk("t5_async", 0,0,0,0,8'h00,2'd0, 0,0,0,8'h00,2'd0, 0,0,0);
    checkOutput(t);
    @(posedge sys_clk);
    #2 reset_n = 1'b1;
    @(negedge sys_clk);
    t = mk("t5_c", 0,1,0,1,8'h0C,2'd1, 0,0,0,8'h00,2'd0, 0,0,1);
    applyStimulus(t); checkOutput(t);
    t = mk("t5_i0", 0,0,0,0,8'h00,2'd0, 0,0,0,8'h00,2'd0, 0,0,1);
    applyStimulus(t); checkOutput(t);
    t = mk("t5_i1", 0,0,0,0,8'h00,2'd0, 0,0,0,8'h00,2'd0, 0,0,1);
    applyStimulus(t); checkOutput(t);

    // Saturation on the 2-bit copy, then clear beating a same-cycle drop
    t = mk("t6_clr", 1,0,0,0,8'h00,2'd0, 0,0,0,8'h00,2'd0, 0,0,0);
    applyStimulus(t); checkOutput(t);
    checkVal("t6_sat_clr", 32'(drop_count2), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      t = mk($sformatf("t6_s%0d", k), 0,1,0,0,8'(k),2'd0, 0,0,0,8'h00,2'd0, 0,0,k);
      applyStimulus(t); checkOutput(t);
      checkVal($sformatf("t6_sat%0d", k), 32'(drop_count2), (k > 3) ? 32'd3 : 32'(k));
    end
    t = mk("t6_s6clr", 1,1,0,0,8'h06,2'd0, 0,0,0,8'h00,2'd0, 0,0,0);
    applyStimulus(t); checkOutput(t);
    checkVal("t6_sat_clr6", 32'(drop_count2), 32'd0);
    checkVal("t6_sat_out", 32'(out2_if.valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
